// File: rtl/div_real_seq.sv
// Purpose : iterative restoring divider, q = a / b on signed fixed-point operands (value = mantissa * 2^exponent).
// Latency : operands accepted at edge k produce out_valid at edge k+DW+2; one operation in flight at a time.
// Backpres: in_ready is low from acceptance until the result handshakes; the result is held while out_ready is low.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a_i: WA-bit signed, b_i: WB-bit signed)
//   out_valid / out_ready result handshake (q_o: WQ-bit signed)
//   div0_o               divisor was zero (q_o saturated by the sign of a, or 0 for 0/0)
//   ovf_o                quotient magnitude exceeded the q_o range and was saturated
module div_real_seq #(
    parameter int WA = 16,
    parameter int EA = -8,
    parameter int WB = 17,
    parameter int EB = -9,
    parameter int WQ = 20,
    parameter int EQ = -10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] a_i,
    input  logic [WB-1:0] b_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WQ-1:0] q_o,
    output logic          div0_o,
    output logic          ovf_o
);

    // Aligning a/b onto the q grid needs the dividend scaled up by SHIFT;
    // a negative SHIFT would need a right shift of the quotient instead,
    // which this unit does not implement.
    localparam int SHIFT = EA - EB - EQ;
    // Dividend magnitude width, which is also the number of iterations.
    localparam int DW    = WA + SHIFT;
    localparam int CW    = $clog2(DW + 1);
    // Comparison width wide enough for both the raw quotient and q range.
    localparam int MW    = (DW > WQ) ? DW : WQ;

    generate
        if (SHIFT < 0) begin : g_bad_shift
            $error("div_real_seq: EA - EB - EQ must be non-negative");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WQ-1:0] Q_MAX = {1'b0, {(WQ-1){1'b1}}};
    localparam logic [WQ-1:0] Q_MIN = {1'b1, {(WQ-2){1'b0}}, 1'b1};  // -Q_MAX

    logic [1:0]    state;
    logic [CW-1:0] count;
    // dq starts as the scaled dividend; each step shifts one dividend bit
    // out of the top and one quotient bit in at the bottom, so after DW
    // steps it holds the quotient magnitude.
    logic [DW-1:0] dq;
    logic [WB-1:0] rem;
    logic [WB-1:0] b_mag;
    logic          q_neg;
    logic          a_neg;
    logic          a_zero;
    logic          b_zero;

    // ------------------------------------------------------------------
    // Operand conditioning at capture time
    // ------------------------------------------------------------------
    logic [WA-1:0] a_mag_c;
    logic [WB-1:0] b_mag_c;

    // The two's-complement negate of the most negative value wraps to the
    // correct unsigned magnitude, so no extra bit is needed.
    always_comb begin
        a_mag_c = a_i[WA-1] ? (~a_i + {{(WA-1){1'b0}}, 1'b1}) : a_i;
        b_mag_c = b_i[WB-1] ? (~b_i + {{(WB-1){1'b0}}, 1'b1}) : b_i;
    end

    // ------------------------------------------------------------------
    // One restoring shift-subtract step
    // ------------------------------------------------------------------
    logic [WB:0]   rem_sh;
    logic [WB+1:0] trial;
    logic          q_bit;
    logic [WB-1:0] rem_nxt;
    logic [DW-1:0] dq_nxt;

    // rem < |b| <= 2^(WB-1), so the shifted remainder fits in WB+1 bits
    // and the trial difference needs one more bit for its sign. With b = 0
    // the remainder is meaningless; the step still runs to keep latency
    // data-independent and the quotient is discarded in FIN.
    always_comb begin
        rem_sh  = {rem, dq[DW-1]};
        trial   = {1'b0, rem_sh} - {2'b00, b_mag};
        q_bit   = ~trial[WB+1];
        rem_nxt = q_bit ? trial[WB-1:0] : rem_sh[WB-1:0];
        dq_nxt  = {dq[DW-2:0], q_bit};
    end

    // ------------------------------------------------------------------
    // Final sign, saturation and divide-by-zero handling
    // ------------------------------------------------------------------
    logic [MW-1:0] m_ext;
    logic [WQ-1:0] m_q;
    logic [WQ-1:0] res_q;
    logic          res_div0;
    logic          res_ovf;

    always_comb begin
        m_ext    = MW'(dq);
        m_q      = m_ext[WQ-1:0];
        res_q    = '0;
        res_div0 = 1'b0;
        res_ovf  = 1'b0;
        if (b_zero) begin
            // Saturate toward the sign of the dividend alone; 0/0 gives 0.
            res_div0 = 1'b1;
            if (!a_zero) begin
                res_q = a_neg ? Q_MIN : Q_MAX;
            end
        end else if (m_ext > MW'(Q_MAX)) begin
            res_ovf = 1'b1;
            res_q   = q_neg ? Q_MIN : Q_MAX;
        end else begin
            // Negating a zero magnitude yields +0, so no negative zero.
            res_q = q_neg ? (~m_q + {{(WQ-1){1'b0}}, 1'b1}) : m_q;
        end
    end

    // ------------------------------------------------------------------
    // Control and state registers
    // ------------------------------------------------------------------
    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            dq        <= '0;
            rem       <= '0;
            b_mag     <= '0;
            q_neg     <= 1'b0;
            a_neg     <= 1'b0;
            a_zero    <= 1'b0;
            b_zero    <= 1'b0;
            out_valid <= 1'b0;
            q_o       <= '0;
            div0_o    <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dq     <= DW'(a_mag_c) << SHIFT;
                        rem    <= '0;
                        b_mag  <= b_mag_c;
                        q_neg  <= a_i[WA-1] ^ b_i[WB-1];
                        a_neg  <= a_i[WA-1];
                        a_zero <= (a_i == '0);
                        b_zero <= (b_i == '0);
                        count  <= CW'(DW);
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    // DW steps while the counter is non-zero, then one
                    // cycle to hand over to FIN.
                    if (count != '0) begin
                        rem   <= rem_nxt;
                        dq    <= dq_nxt;
                        count <= count - CW'(1);
                    end else begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    q_o       <= res_q;
                    div0_o    <= res_div0;
                    ovf_o     <= res_ovf;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // Result and flags stay as they are after the
                    // handshake; only out_valid drops.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_real_seq.sv
module tb_div_real_seq;

    localparam int WA    = 16;
    localparam int WB    = 17;
    localparam int WQ    = 20;
    localparam int SHIFT = 11;           // (-8) - (-9) - (-10)
    localparam int LAT   = 29;           // edges from capture to out_valid
    localparam longint QMAX = 524287;    // 2^(WQ-1)-1

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a_i;
    logic [WB-1:0] b_i;
    logic          out_valid;
    logic          out_ready;
    logic [WQ-1:0] q_o;
    logic          div0_o;
    logic          ovf_o;

    typedef struct {
        longint q;
        bit     d0;
        bit     ov;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    div_real_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_o       (q_o),
        .div0_o    (div0_o),
        .ovf_o     (ovf_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint am;
        longint bm;
        longint m;
        bit     s;
        am = (a < 0) ? -a : a;
        bm = (b < 0) ? -b : b;
        s  = (a < 0) != (b < 0);
        e.q = 0; e.d0 = 0; e.ov = 0;
        if (b == 0) begin
            e.d0 = 1;
            e.q  = (a == 0) ? 0 : ((a < 0) ? -QMAX : QMAX);
        end else begin
            m = (am << SHIFT) / bm;
            if (m > QMAX) begin
                e.ov = 1;
                e.q  = s ? -QMAX : QMAX;
            end else begin
                e.q = s ? -m : m;
            end
        end
        return e;
    endfunction

    // Present operands for exactly one accepting edge.
    task automatic launch(input int a, input int b, input bit push);
        @(negedge clk);
        chk("in_ready_before_launch", longint'(in_ready), 1);
        a_i      = a[WA-1:0];
        b_i      = b[WB-1:0];
        in_valid = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen (sampled 1 ns after each edge).
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) chk("out_valid_timeout", longint'(out_valid), 1);
    endtask

    task automatic check_result(input string tag, output longint eq);
        exp_t e;
        eq = 0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e  = sb.pop_front();
            eq = e.q;
            chk({tag, "_q"},    longint'($signed(q_o)), e.q);
            chk({tag, "_div0"}, longint'(div0_o), longint'(e.d0));
            chk({tag, "_ovf"},  longint'(ovf_o),  longint'(e.ov));
        end
    endtask

    task automatic full_txn(input string tag, input int a, input int b);
        int     lat;
        longint eq;
        launch(a, b, 1'b1);
        wait_result(lat);
        chk({tag, "_latency"}, lat, LAT);
        check_result(tag, eq);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, longint'(out_valid), 0);
        chk({tag, "_ready_back"}, longint'(in_ready), 1);
    endtask

    initial begin
        int     lat;
        int     seen;
        longint eq;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a_i         = '0;
        b_i         = '0;

        #12;
        chk("rst_in_ready",  longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_q",         longint'(q_o), 0);
        chk("rst_div0",      longint'(div0_o), 0);
        chk("rst_ovf",       longint'(ovf_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function: signs, truncation, saturation, divide-by-zero.
        full_txn("basic",      384,    256);
        full_txn("neg_a",      -256,   192);
        full_txn("neg_b",      256,    -192);
        full_txn("neg_both",   -256,   -192);
        full_txn("ovf_pos",    32767,  1);
        full_txn("ovf_neg",    -32768, 1);
        full_txn("div0_neg",   -256,   0);
        full_txn("div0_zero",  0,      0);
        full_txn("small_zero", 1,      -65536);
        full_txn("trunc_neg",  -1,     3);
        full_txn("zero_num",   0,      5);

        // Backpressure, with in_valid pulses while busy.
        out_ready = 1'b0;
        launch(384, 256, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_calc", longint'(in_ready), 0);
        a_i = 16'd1000; b_i = 17'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp_latency", lat + 6, LAT);
        check_result("bp", eq);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a_i = -16'sd5; b_i = 17'd7; in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_q_stable",  longint'($signed(q_o)), eq);
            chk("bp_valid_held", longint'(out_valid), 1);
            chk("bp_ready_done", longint'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", longint'(out_valid), 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("bp_no_extra_result", seen, 0);

        // Asynchronous reset in the middle of CALC (count about 10).
        launch(384, 256, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_q",         longint'(q_o), 0);
        chk("arst_div0",      longint'(div0_o), 0);
        chk("arst_ovf",       longint'(ovf_o), 0);
        chk("arst_in_ready",  longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("arst_no_pulse", seen, 0);
        full_txn("post_rst", 384, 256);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
